// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch - instruction fetch stage between the PC and the instruction bus.
//
// Latches the PC, issues a word read, waits for mem_ack, captures the returned
// word into `instr` and pulses `iready` for one cycle so the PC can advance.
// A fetch takes at least 3 cycles: IDLE -> REQ -> DONE.
//
// Optional feature: define INSTR_FETCH_TIMEOUT_EN to add a bus-timeout
// watchdog. A REQ lasting TIMEOUT cycles without an ack then parks the block
// in ERR with fetch_err=1 until RST. Without the macro, REQ waits forever and
// fetch_err is tied to 0.
//
// Parameters:
//   TIMEOUT    max REQ cycles without ack before ERR (2..65535, watchdog only)
// Ports:
//   clk        system clock, rising edge
//   RST        synchronous active-high reset
//   PCaddr     current PC, sampled on IDLE->REQ
//   hold       downstream stall, blocks a new fetch while in IDLE
//   mem_ack    bus acknowledge, mem_rdata valid in the same cycle
//   mem_rdata  instruction word from memory
//   mem_ren    read request, high for the whole REQ state
//   mem_addr   word-aligned request address
//   instr      last fetched instruction (NOP after reset)
//   iready     one-cycle pulse: instr is new
//   fetch_err  sticky bus-timeout flag
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] PCaddr,
  input  logic        hold,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_ren,
  output logic [31:0] mem_addr,
  output logic [31:0] instr,
  output logic        iready,
  output logic        fetch_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("instr_fetch: TIMEOUT must be in 2..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] instr_q, instr_d;

`ifdef INSTR_FETCH_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  // Byte offset of a misaligned PC is silently dropped on the bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_q[1:0];

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      instr_q <= NOP;
`ifdef INSTR_FETCH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
`ifdef INSTR_FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
`ifdef INSTR_FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!hold) begin
          addr_d  = PCaddr;
          state_d = REQ;
`ifdef INSTR_FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        // An ack always wins, even in the cycle the watchdog would fire.
        if (mem_ack) begin
          instr_d = mem_rdata;
          state_d = DONE;
        end
`ifdef INSTR_FETCH_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      DONE: state_d = IDLE;
`ifdef INSTR_FETCH_TIMEOUT_EN
      ERR:  state_d = ERR;
`else
      ERR:  state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  assign mem_ren   = (state_q == REQ);
  assign iready    = (state_q == DONE);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign instr     = instr_q;
`ifdef INSTR_FETCH_TIMEOUT_EN
  assign fetch_err = (state_q == ERR);
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch - directed self-checking bench for instr_fetch.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at
// the same point, so each step() shows the state entered on that edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        RST;
  logic [31:0] PCaddr;
  logic        hold;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic [31:0] instr;
  logic        iready;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  instr_fetch #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .RST       (RST),
    .PCaddr    (PCaddr),
    .hold      (hold),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_ren   (mem_ren),
    .mem_addr  (mem_addr),
    .instr     (instr),
    .iready    (iready),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; hold = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    PCaddr = 32'h0000_0FF0;
    step(); step();
    total++; if (mem_ren !== 1'b0)   begin bad++; $display("FAIL reset_ren got=%b exp=0", mem_ren); end
    total++; if (iready !== 1'b0)    begin bad++; $display("FAIL reset_iready got=%b exp=0", iready); end
    total++; if (instr !== NOP)      begin bad++; $display("FAIL reset_instr got=%h exp=%h", instr, NOP); end
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", fetch_err); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    RST = 1'b0; mem_ack = 1'b0;
    step();
  endtask

  task automatic test_ack_outside_req();
    // Parked in IDLE by hold; a stray ack must not touch instr.
    hold = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (instr !== NOP || iready !== 1'b0 || mem_ren !== 1'b0) begin
        bad++; $display("FAIL stray_ack instr=%h iready=%b ren=%b exp instr=%h 0 0", instr, iready, mem_ren, NOP);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_zero_wait();
    PCaddr = 32'h0000_0100; mem_rdata = 32'h0050_0093; mem_ack = 1'b1; hold = 1'b0;
    step();  // REQ
    total++; if (mem_ren !== 1'b1 || mem_addr !== 32'h100) begin
      bad++; $display("FAIL zw_req ren=%b addr=%h exp 1 00000100", mem_ren, mem_addr);
    end
    total++; if (iready !== 1'b0) begin bad++; $display("FAIL zw_req_iready got=%b exp=0", iready); end
    hold = 1'b1;  // rises before DONE; pulse must still happen
    step();  // DONE
    total++; if (iready !== 1'b1 || instr !== 32'h0050_0093 || mem_ren !== 1'b0) begin
      bad++; $display("FAIL zw_done iready=%b instr=%h ren=%b exp 1 00500093 0", iready, instr, mem_ren);
    end
    mem_ack = 1'b0;
    step();  // IDLE, blocked by hold
    total++; if (iready !== 1'b0 || mem_ren !== 1'b0) begin
      bad++; $display("FAIL zw_idle iready=%b ren=%b exp 0 0", iready, mem_ren);
    end
    step();
    total++; if (mem_ren !== 1'b0) begin bad++; $display("FAIL zw_hold_block ren=%b exp=0", mem_ren); end
  endtask

  task automatic test_wait_states();
    int ren_cnt = 0;
    int rdy_cnt = 0;
    PCaddr = 32'h0000_0203; mem_rdata = 32'hAAAA_5555; mem_ack = 1'b0; hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (mem_ren === 1'b1) ren_cnt++;
      if (iready === 1'b1) rdy_cnt++;
      total++; if (mem_addr !== 32'h200) begin bad++; $display("FAIL ws_addr cyc=%0d got=%h exp=00000200", i, mem_addr); end
      total++; if (instr !== 32'h0050_0093) begin bad++; $display("FAIL ws_instr_hold cyc=%0d got=%h exp=00500093", i, instr); end
      if (i == 4) mem_ack = 1'b1;
    end
    hold = 1'b1;
    step();  // DONE
    if (iready === 1'b1) rdy_cnt++;
    if (mem_ren === 1'b1) ren_cnt++;
    total++; if (instr !== 32'hAAAA_5555) begin bad++; $display("FAIL ws_instr got=%h exp=aaaa5555", instr); end
    mem_ack = 1'b0;
    step(); step();
    if (iready === 1'b1) rdy_cnt++;
    total++; if (ren_cnt !== 4) begin bad++; $display("FAIL ws_ren_cycles got=%0d exp=4", ren_cnt); end
    total++; if (rdy_cnt !== 1) begin bad++; $display("FAIL ws_iready_pulses got=%0d exp=1", rdy_cnt); end
  endtask

  task automatic test_hold();
    hold = 1'b1; PCaddr = 32'h0000_0300; mem_ack = 1'b0; mem_rdata = 32'h0000_0300;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (mem_ren !== 1'b0) begin bad++; $display("FAIL hold_idle cyc=%0d ren=%b exp=0", i, mem_ren); end
    end
    hold = 1'b0;
    step();  // REQ
    total++; if (mem_ren !== 1'b1 || mem_addr !== 32'h300) begin
      bad++; $display("FAIL hold_release ren=%b addr=%h exp 1 00000300", mem_ren, mem_addr);
    end
    hold = 1'b1; step();
    total++; if (mem_ren !== 1'b1) begin bad++; $display("FAIL hold_in_req1 ren=%b exp=1", mem_ren); end
    hold = 1'b0; step();
    total++; if (mem_ren !== 1'b1) begin bad++; $display("FAIL hold_in_req2 ren=%b exp=1", mem_ren); end
    hold = 1'b1; mem_ack = 1'b1;
    step();
    total++; if (iready !== 1'b1 || instr !== 32'h0000_0300) begin
      bad++; $display("FAIL hold_done iready=%b instr=%h exp 1 00000300", iready, instr);
    end
    mem_ack = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc = 32'h0000_0400;
    logic        prev_rdy = 1'b0;
    int          pulses = 0;
    PCaddr = pc; mem_rdata = 32'h1000_0000 | pc; mem_ack = 1'b1; hold = 1'b0;
    for (int s = 1; s <= 9; s++) begin
      step();
      total++; if (iready !== ((s % 3) == 2)) begin
        bad++; $display("FAIL b2b_iready step=%0d got=%b exp=%b", s, iready, (s % 3) == 2);
      end
      if ((s % 3) == 1) begin
        total++; if (mem_addr !== pc) begin bad++; $display("FAIL b2b_addr step=%0d got=%h exp=%h", s, mem_addr, pc); end
      end
      if (prev_rdy === 1'b1 && iready === 1'b1) begin
        total++; bad++; $display("FAIL b2b_double_pulse step=%0d got=11 exp=not 11", s);
      end
      prev_rdy = iready;
      if (iready === 1'b1) begin
        pulses++;
        total++; if (instr !== (32'h1000_0000 | pc)) begin
          bad++; $display("FAIL b2b_instr step=%0d got=%h exp=%h", s, instr, 32'h1000_0000 | pc);
        end
        pc = pc + 32'd4;
        PCaddr = pc; mem_rdata = 32'h1000_0000 | pc;
      end
    end
    total++; if (pulses !== 3) begin bad++; $display("FAIL b2b_pulses got=%0d exp=3", pulses); end
    hold = 1'b1; mem_ack = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_req();
    hold = 1'b0; mem_ack = 1'b0; PCaddr = 32'h0000_0500;
    step(); step();  // REQ, waiting
    total++; if (mem_ren !== 1'b1) begin bad++; $display("FAIL rst_mid_pre ren=%b exp=1", mem_ren); end
    RST = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    step();
    total++; if (mem_ren !== 1'b0 || iready !== 1'b0 || instr !== NOP || mem_addr !== 32'h0) begin
      bad++; $display("FAIL rst_mid ren=%b iready=%b instr=%h addr=%h exp 0 0 %h 0", mem_ren, iready, instr, mem_addr, NOP);
    end
    RST = 1'b0; mem_ack = 1'b0; hold = 1'b1;
    step();
    total++; if (iready !== 1'b0 || instr !== NOP) begin
      bad++; $display("FAIL rst_mid_after iready=%b instr=%h exp 0 %h", iready, instr, NOP);
    end
  endtask

  task automatic test_long_wait();
    // Well past TIMEOUT=4: without the watchdog REQ simply keeps waiting.
    hold = 1'b0; mem_ack = 1'b0; PCaddr = 32'h0000_0700; mem_rdata = 32'h0000_0777;
    for (int i = 1; i <= 10; i++) begin
      step();
      total++; if (mem_ren !== 1'b1 || fetch_err !== 1'b0) begin
        bad++; $display("FAIL long_wait cyc=%0d ren=%b err=%b exp 1 0", i, mem_ren, fetch_err);
      end
    end
    mem_ack = 1'b1; hold = 1'b1;
    step();
    total++; if (iready !== 1'b1 || instr !== 32'h0000_0777) begin
      bad++; $display("FAIL long_wait_done iready=%b instr=%h exp 1 00000777", iready, instr);
    end
    mem_ack = 1'b0;
    step();
  endtask

  task automatic test_watchdog();
    hold = 1'b0; mem_ack = 1'b0; PCaddr = 32'h0000_0600;
    for (int i = 1; i <= 4; i++) begin
      step();
      total++; if (mem_ren !== 1'b1 || fetch_err !== 1'b0) begin
        bad++; $display("FAIL wd_req cyc=%0d ren=%b err=%b exp 1 0", i, mem_ren, fetch_err);
      end
    end
    step();  // ERR
    total++; if (fetch_err !== 1'b1 || mem_ren !== 1'b0 || iready !== 1'b0) begin
      bad++; $display("FAIL wd_err err=%b ren=%b iready=%b exp 1 0 0", fetch_err, mem_ren, iready);
    end
    mem_ack = 1'b1;
    step(); step();
    total++; if (fetch_err !== 1'b1 || mem_ren !== 1'b0 || iready !== 1'b0) begin
      bad++; $display("FAIL wd_sticky err=%b ren=%b iready=%b exp 1 0 0", fetch_err, mem_ren, iready);
    end
    RST = 1'b1; mem_ack = 1'b0; step();
    RST = 1'b0;
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL wd_clear err=%b exp=0", fetch_err); end
    // Ack on the 4th REQ cycle beats the timeout.
    mem_rdata = 32'h0000_0666;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 4) mem_ack = 1'b1;
    end
    hold = 1'b1;
    step();
    total++; if (iready !== 1'b1 || fetch_err !== 1'b0 || instr !== 32'h0000_0666) begin
      bad++; $display("FAIL wd_ack_wins iready=%b err=%b instr=%h exp 1 0 00000666", iready, fetch_err, instr);
    end
    mem_ack = 1'b0;
    step();
  endtask

  initial begin
    RST = 1'b1; hold = 1'b1; mem_ack = 1'b0; mem_rdata = '0; PCaddr = '0;
    test_reset();
    test_ack_outside_req();
    test_zero_wait();
    test_wait_states();
    test_hold();
    test_back_to_back();
    test_reset_mid_req();
`ifdef INSTR_FETCH_TIMEOUT_EN
    test_watchdog();
`else
    test_long_wait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net in case the sequence stalls.
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d exp=finish", total, bad);
    $fatal(1);
  end

endmodule
